// File: rtl/pic_control_unit_if.sv
// ALU opcode encoding shared by the control unit and ALU, plus the
// control-unit <-> core/ALU signal bundle.
package pic_alu_ops_pkg;
  localparam logic [3:0] ALU_ZERO   = 4'd0;
  localparam logic [3:0] ALU_ADD    = 4'd1;
  localparam logic [3:0] ALU_SUB    = 4'd2;
  localparam logic [3:0] ALU_AND    = 4'd3;
  localparam logic [3:0] ALU_OR     = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_COM    = 4'd6;
  localparam logic [3:0] ALU_DEC    = 4'd7;
  localparam logic [3:0] ALU_INC    = 4'd8;
  localparam logic [3:0] ALU_PASSLF = 4'd9;
  localparam logic [3:0] ALU_PASSW  = 4'd10;
  localparam logic [3:0] ALU_RLF    = 4'd11;
  localparam logic [3:0] ALU_RRF    = 4'd12;
  localparam logic [3:0] ALU_SWAPF  = 4'd13;
  localparam logic [3:0] ALU_BC     = 4'd14;
  localparam logic [3:0] ALU_BS     = 4'd15;
endpackage

interface pic_control_unit_if #(
  parameter int PC_W = 11,
  parameter int F_W  = 7
);
  logic [13:0]     instr;
  logic            alu_out_z;
  logic            alu_bit_test_res;
  logic [1:0]      q_phase;
  logic [3:0]      alu_op;
  logic            alu_d;
  logic            alu_status_wr_en;
  logic [2:0]      alu_b_in;
  logic            lf_sel_literal;
  logic [7:0]      literal;
  logic [F_W-1:0]  f_addr;
  logic            w_wr_en;
  logic            f_wr_en;
  logic            pc_inc;
  logic            pc_load;
  logic [PC_W-1:0] pc_load_addr;
  logic            stack_push;
  logic            stack_pop;
  logic            gie_set;

  modport master (
    input  instr, alu_out_z, alu_bit_test_res,
    output q_phase, alu_op, alu_d, alu_status_wr_en, alu_b_in, lf_sel_literal,
           literal, f_addr, w_wr_en, f_wr_en, pc_inc, pc_load, pc_load_addr,
           stack_push, stack_pop, gie_set
  );

  modport slave (
    output instr, alu_out_z, alu_bit_test_res,
    input  q_phase, alu_op, alu_d, alu_status_wr_en, alu_b_in, lf_sel_literal,
           literal, f_addr, w_wr_en, f_wr_en, pc_inc, pc_load, pc_load_addr,
           stack_push, stack_pop, gie_set
  );
endinterface

// File: rtl/pic_control_unit.sv
// PIC16 mid-range instruction sequencer: Q1..Q4 phase counter, instruction
// register, opcode decode, Q4 strobes and skip/branch flush of the prefetch.
module pic_control_unit
  import pic_alu_ops_pkg::*;
#(
  parameter int PC_W = 11,
  parameter int F_W  = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  pic_control_unit_if.master  cu
);

  logic [1:0]  q_q, q_d;
  logic [13:0] ir_q, ir_d;
  logic        flush_q, flush_d;

  logic [3:0] dec_op;
  logic       dec_d, dec_lf, dec_wr_w, dec_wr_f, dec_st;
  logic       dec_push, dec_pop, dec_gie, dec_jump, dec_ret;
  logic       dec_skip_z, dec_skip_bt;
  logic       q4, exec, skip;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q     <= 2'd0;
      ir_q    <= 14'h0000;
      flush_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      ir_q    <= ir_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    dec_op      = ALU_ZERO;
    dec_d       = 1'b0;
    dec_lf      = 1'b0;
    dec_wr_w    = 1'b0;
    dec_wr_f    = 1'b0;
    dec_st      = 1'b0;
    dec_push    = 1'b0;
    dec_pop     = 1'b0;
    dec_gie     = 1'b0;
    dec_jump    = 1'b0;
    dec_ret     = 1'b0;
    dec_skip_z  = 1'b0;
    dec_skip_bt = 1'b0;
    case (ir_q[13:12])
      2'b00: begin
        if (ir_q[11:8] == 4'h0) begin
          if (ir_q[7]) begin
            dec_op   = ALU_PASSW;
            dec_d    = 1'b1;
            dec_wr_f = 1'b1;
          end else if (ir_q[7:0] == 8'h08) begin
            dec_pop = 1'b1;
            dec_ret = 1'b1;
          end else if (ir_q[7:0] == 8'h09) begin
            dec_pop = 1'b1;
            dec_gie = 1'b1;
            dec_ret = 1'b1;
          end
        end else begin
          // Byte-oriented ops, CLRF/CLRW included: d selects W or f.
          dec_d    = ir_q[7];
          dec_wr_w = ~ir_q[7];
          dec_wr_f = ir_q[7];
          dec_st   = 1'b1;
          case (ir_q[11:8])
            4'h1: dec_op = ALU_ZERO;
            4'h2: dec_op = ALU_SUB;
            4'h3: dec_op = ALU_DEC;
            4'h4: dec_op = ALU_OR;
            4'h5: dec_op = ALU_AND;
            4'h6: dec_op = ALU_XOR;
            4'h7: dec_op = ALU_ADD;
            4'h8: dec_op = ALU_PASSLF;
            4'h9: dec_op = ALU_COM;
            4'hA: dec_op = ALU_INC;
            4'hB: begin dec_op = ALU_DEC; dec_st = 1'b0; dec_skip_z = 1'b1; end
            4'hC: dec_op = ALU_RRF;
            4'hD: dec_op = ALU_RLF;
            4'hE: begin dec_op = ALU_SWAPF; dec_st = 1'b0; end
            default: begin dec_op = ALU_INC; dec_st = 1'b0; dec_skip_z = 1'b1; end
          endcase
        end
      end
      2'b01: begin
        dec_op = ir_q[10] ? ALU_BS : ALU_BC;
        if (ir_q[11]) begin
          dec_skip_bt = 1'b1;
        end else begin
          dec_d    = 1'b1;
          dec_wr_f = 1'b1;
        end
      end
      2'b10: begin
        dec_jump = 1'b1;
        dec_push = ~ir_q[11];
      end
      default: begin
        dec_lf   = 1'b1;
        dec_wr_w = 1'b1;
        casez (ir_q[11:8])
          4'b00??: dec_op = ALU_PASSLF;
          4'b01??: begin dec_op = ALU_PASSLF; dec_pop = 1'b1; dec_ret = 1'b1; end
          4'b1000: begin dec_op = ALU_OR;  dec_st = 1'b1; end
          4'b1001: begin dec_op = ALU_AND; dec_st = 1'b1; end
          4'b1010: begin dec_op = ALU_XOR; dec_st = 1'b1; end
          4'b110?: begin dec_op = ALU_SUB; dec_st = 1'b1; end
          4'b111?: begin dec_op = ALU_ADD; dec_st = 1'b1; end
          default: dec_wr_w = 1'b0;
        endcase
      end
    endcase
  end

  // A flushed cycle still fetches and increments the PC but commits nothing.
  assign q4   = (q_q == 2'd3);
  assign exec = q4 & ~flush_q;
  assign skip = (dec_skip_z & cu.alu_out_z) | (dec_skip_bt & cu.alu_bit_test_res);

  always_comb begin
    q_d     = q_q + 2'd1;
    ir_d    = ir_q;
    flush_d = flush_q;
    if (q4) begin
      ir_d    = cu.instr;
      flush_d = ~flush_q & (skip | dec_jump | dec_ret);
    end
  end

  always_comb begin
    cu.q_phase          = q_q;
    cu.alu_op           = dec_op;
    cu.alu_d            = dec_d;
    cu.alu_b_in         = ir_q[9:7];
    cu.lf_sel_literal   = dec_lf;
    cu.literal          = ir_q[7:0];
    cu.f_addr           = ir_q[F_W-1:0];
    cu.pc_load_addr     = dec_jump ? ir_q[PC_W-1:0] : '0;
    cu.w_wr_en          = exec & dec_wr_w;
    cu.f_wr_en          = exec & dec_wr_f;
    cu.alu_status_wr_en = exec & dec_st;
    cu.stack_push       = exec & dec_push;
    cu.stack_pop        = exec & dec_pop;
    cu.gie_set          = exec & dec_gie;
    cu.pc_load          = exec & (dec_jump | dec_ret);
    cu.pc_inc           = q4 & ~(exec & (dec_jump | dec_ret));
  end

endmodule
